product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/acc_pkg.sv | 15 +
 rtl/acc_adder.sv | 24 ++
 rtl/product_accumulator.sv | 108 ++++++++++
 tb/tb_product_accumulator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the product accumulator: FSM encoding and default widths.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ACC_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    // Width of the product arriving from the upstream 2x2 multiplier.
    localparam int P_W       = 4;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: adds a zero-extended product to the running total and
// reports the carry out of the top bit so the caller can flag overflow.
module acc_adder
    import acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [P_W-1:0]   p,
    output logic [ACC_W-1:0] s,
    output logic             carry
);

    logic [ACC_W:0] wide;

    // One extra bit holds the carry; the low ACC_W bits wrap naturally.
    always_comb begin
        wide = {1'b0, a} + {{(ACC_W + 1 - P_W){1'b0}}, p};
    end

    assign s     = wide[ACC_W-1:0];
    assign carry = wide[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of len products with valid/ready handshakes,
// then holds the total (and a sticky overflow flag) until the consumer takes it.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [P_W-1:0]   P,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic             carry;
    logic             ovf_r;
    logic             accept;
    logic             last_accept;

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a     (acc),
        .p     (P),
        .s     (acc_add),
        .carry (carry)
    );

    // Handshake qualifiers; ACCUM always has remaining >= 1, so ==1 marks the final product.
    always_comb begin
        accept      = in_valid && (state == ACCUM);
        last_accept = accept && (remaining == LEN_W'(1));
    end

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE, so a start during the
    // HOLD-to-IDLE handoff is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (last_accept) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run datapath: load on start, accumulate on each accept, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            ovf_r     <= 1'b0;
        end else if (state == IDLE && start) begin
            remaining <= len;
            acc       <= '0;
            ovf_r     <= 1'b0;
        end else if (accept) begin
            remaining <= remaining - LEN_W'(1);
            acc       <= acc_add;
            ovf_r     <= ovf_r | carry;
        end
    end

    // Outputs decode state only and read the registers directly, so nothing
    // combinational runs from P or in_valid to the outputs.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
        sum       = acc;
        ovf       = ovf_r;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: default-width and 6-bit instances
// share the same stimulus; a queue holds the expected result of each run.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] p;
    logic       out_ready;

    logic       ir8, ov8, ovf8, busy8;
    logic [7:0] sum8;
    logic       ir6, ov6, ovf6, busy6;
    logic [5:0] sum6;

    typedef struct packed {
        logic [7:0] s8;
        logic       o8;
        logic [5:0] s6;
        logic       o6;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    product_accumulator dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .P         (p),
        .in_ready  (ir8),
        .out_valid (ov8),
        .out_ready (out_ready),
        .sum       (sum8),
        .ovf       (ovf8),
        .busy      (busy8)
    );

    product_accumulator #(.ACC_W(6), .LEN_W(4)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .P         (p),
        .in_ready  (ir6),
        .out_valid (ov6),
        .out_ready (out_ready),
        .sum       (sum6),
        .ovf       (ovf6),
        .busy      (busy6)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Expected result of a run from the plain integer total of its products.
    task automatic push_exp(input int tot);
        res_t r;
        r.s8 = 8'(tot);
        r.o8 = (tot > 255);
        r.s6 = 6'(tot);
        r.o6 = (tot > 63);
        exp_q.push_back(r);
    endtask

    task automatic start_run(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 4'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        p        = 4'(v);
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [5:0] st;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; p = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        st = {busy8, ir8, ov8, busy6, ir6, ov6};
        total++;
        if (st !== 6'b0) begin bad++; $display("FAIL reset_status got=%b want=000000", st); end
        total++;
        if ({sum8, ovf8, sum6, ovf6} !== 16'h0) begin
            bad++; $display("FAIL reset_sum got=%h/%b %h/%b want=0", sum8, ovf8, sum6, ovf6);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b want=0", busy8); end
    endtask

    task automatic test_basic_run();
        int   cyc;
        res_t got, want;
        push_exp(9 + 6 + 4);
        start_run(3);
        total++;
        if ({busy8, ir8, ov8} !== 3'b110) begin bad++; $display("FAIL s1_accum_status got=%b want=110", {busy8, ir8, ov8}); end
        feed(9);
        feed(6);
        total++;
        if (ov8 !== 1'b0) begin bad++; $display("FAIL s1_early_valid got=%b want=0", ov8); end
        feed(4);
        in_valid = 1'b0;
        wait_out(cyc);
        total++;
        if (cyc != 0) begin bad++; $display("FAIL s1_latency got=%0d want=0 extra cycles", cyc); end
        got = {sum8, ovf8, sum6, ovf6};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL s1_result queue empty got=%h", got); end
        else begin
            want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL s1_result got=%h want=%h", got, want); end
        end
        release_out();
        total++;
        if ({busy8, ir8, ov8} !== 3'b000) begin bad++; $display("FAIL s1_release got=%b want=000", {busy8, ir8, ov8}); end
    endtask

    task automatic test_zero_len();
        int   cyc;
        res_t got, want;
        push_exp(0);
        start_run(0);
        total++;
        if ({busy8, ir8, ov8, ir6} !== 4'b1010) begin
            bad++; $display("FAIL s2_hold_status got=%b want=1010", {busy8, ir8, ov8, ir6});
        end
        wait_out(cyc);
        total++;
        if (cyc != 0) begin bad++; $display("FAIL s2_latency got=%0d want=0", cyc); end
        got = {sum8, ovf8, sum6, ovf6};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL s2_result queue empty got=%h", got); end
        else begin
            want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL s2_result got=%h want=%h", got, want); end
        end
        release_out();
    endtask

    task automatic test_overflow();
        int   cyc;
        res_t got, want;
        push_exp(8 * 9);
        start_run(8);
        for (int i = 0; i < 8; i++) feed(9);
        in_valid = 1'b0;
        wait_out(cyc);
        total++;
        if (cyc != 0) begin bad++; $display("FAIL s3_latency got=%0d want=0", cyc); end
        got = {sum8, ovf8, sum6, ovf6};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL s3_result queue empty got=%h", got); end
        else begin
            want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL s3_result got=%h want=%h", got, want); end
        end
        release_out();
    endtask

    task automatic test_gap_and_hold();
        int   cyc;
        res_t got, want;
        push_exp(3 + 2);
        start_run(2);
        feed(3);
        in_valid = 1'b0;
        p        = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({busy8, ir8, ov8, sum8} !== {3'b110, 8'd3}) begin
                bad++; $display("FAIL s4_gap%0d got=%b/%0d want=110/3", i, {busy8, ir8, ov8}, sum8);
            end
        end
        feed(2);
        in_valid = 1'b0;
        wait_out(cyc);
        total++;
        if (cyc != 0) begin bad++; $display("FAIL s4_latency got=%0d want=0", cyc); end
        got = {sum8, ovf8, sum6, ovf6};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL s4_result queue empty got=%h", got); end
        else begin
            want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL s4_result got=%h want=%h", got, want); end
        end
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            len   = 4'd1;
            @(negedge clk);
            total++;
            if ({ov8, ir8, sum8, ovf8} !== {2'b10, 8'd5, 1'b0}) begin
                bad++; $display("FAIL s4_hold%0d got=%b/%0d/%b want=10/5/0", i, {ov8, ir8}, sum8, ovf8);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        total++;
        if ({busy8, ov8} !== 2'b00) begin bad++; $display("FAIL s4_handoff got=%b want=00", {busy8, ov8}); end
        @(negedge clk);
        total++;
        if ({busy8, ir8} !== 2'b00) begin bad++; $display("FAIL s4_start_ignored got=%b want=00", {busy8, ir8}); end
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        res_t got, want;
        start_run(4);
        feed(5);
        feed(7);
        in_valid = 1'b0;
        total++;
        if (sum8 !== 8'd12) begin bad++; $display("FAIL s5_partial got=%0d want=12", sum8); end
        rst = 1'b1;
        #1;
        total++;
        if ({busy8, ir8, ov8, sum8, ovf8, busy6, sum6} !== 19'h0) begin
            bad++; $display("FAIL s5_async_reset got=%b/%0d/%b want=000/0/0", {busy8, ir8, ov8}, sum8, ovf8);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy8, ov8} !== 2'b00) begin bad++; $display("FAIL s5_wait_idle got=%b want=00", {busy8, ov8}); end
        push_exp(1);
        start_run(1);
        feed(1);
        in_valid = 1'b0;
        wait_out(cyc);
        total++;
        if (cyc != 0) begin bad++; $display("FAIL s5_latency got=%0d want=0", cyc); end
        got = {sum8, ovf8, sum6, ovf6};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL s5_result queue empty got=%h", got); end
        else begin
            want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL s5_result got=%h want=%h", got, want); end
        end
        release_out();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL queue_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_zero_len();
        test_overflow();
        test_gap_and_hold();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
